// File: rtl/input_p4_dispatcher.sv
// rtl/input_p4_dispatcher.sv - buffers one input stream and dispatches whole packets round-robin to five outputs
module input_p4_dispatcher #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 304,
    parameter int C_S_AXIS_TUSER_WIDTH = 304,
    parameter int IN_FIFO_DEPTH_BIT    = 6
) (
    input  logic                                axis_aclk,
    input  logic                                axis_reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    output logic                                s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_0_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_0_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_0_tuser,
    output logic                                m_axis_0_tvalid,
    input  logic                                m_axis_0_tready,
    output logic                                m_axis_0_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_1_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_1_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_1_tuser,
    output logic                                m_axis_1_tvalid,
    input  logic                                m_axis_1_tready,
    output logic                                m_axis_1_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_2_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_2_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_2_tuser,
    output logic                                m_axis_2_tvalid,
    input  logic                                m_axis_2_tready,
    output logic                                m_axis_2_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_3_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_3_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_3_tuser,
    output logic                                m_axis_3_tvalid,
    input  logic                                m_axis_3_tready,
    output logic                                m_axis_3_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_4_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_4_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_4_tuser,
    output logic                                m_axis_4_tvalid,
    input  logic                                m_axis_4_tready,
    output logic                                m_axis_4_tlast,

    input  logic [4:0]                          port_en,

    output logic [31:0]                         pkt_cnt_0,
    output logic [31:0]                         pkt_cnt_1,
    output logic [31:0]                         pkt_cnt_2,
    output logic [31:0]                         pkt_cnt_3,
    output logic [31:0]                         pkt_cnt_4,
    output logic                                pkt_dispatched
);

    localparam int DW    = C_M_AXIS_DATA_WIDTH;
    localparam int KW    = C_M_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_M_AXIS_TUSER_WIDTH;
    localparam int FW    = 1 + UW + KW + DW;
    localparam int DEPTH = 1 << IN_FIFO_DEPTH_BIT;
    localparam logic [IN_FIFO_DEPTH_BIT:0] NF_LEVEL = (IN_FIFO_DEPTH_BIT+1)'(DEPTH - 1);

    typedef enum logic {IDLE, WR_PKT} state_t;

    logic [FW-1:0]                  mem [DEPTH];
    logic [IN_FIFO_DEPTH_BIT-1:0]   wr_ptr;
    logic [IN_FIFO_DEPTH_BIT-1:0]   rd_ptr;
    logic [IN_FIFO_DEPTH_BIT:0]     count;
    logic                           empty;
    logic                           nearly_full;
    logic                           wr_en;
    logic                           rd_en;
    logic [FW-1:0]                  head;
    logic [DW-1:0]                  head_data;
    logic [KW-1:0]                  head_keep;
    logic [UW-1:0]                  head_user;
    logic                           head_last;

    state_t                         state;
    logic [2:0]                     sel_port;
    logic [2:0]                     rr_ptr;
    logic [2:0]                     pick_port;
    logic [3:0]                     pick_idx;
    logic [15:0]                    en_dbl;
    logic [4:0]                     valid_vec;
    logic [4:0]                     ready_vec;
    logic                           pkt_done;

    // Input FIFO: fall-through, head word is always visible combinationally
    assign empty         = (count == '0);
    assign nearly_full   = (count >= NF_LEVEL);
    assign s_axis_tready = !nearly_full && !axis_reset;
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign head          = mem[rd_ptr];
    assign head_data     = head[DW-1:0];
    assign head_keep     = head[DW +: KW];
    assign head_user     = head[DW+KW +: UW];
    assign head_last     = head[FW-1];

    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (!wr_en && rd_en) begin
                count <= count - 1'b1;
            end
        end
    end

    // First enabled port at or after rr_ptr; the doubled mask handles the 4->0 wrap
    always_comb begin
        en_dbl    = {6'b0, port_en, port_en};
        pick_port = rr_ptr;
        pick_idx  = '0;
        for (int i = 4; i >= 0; i--) begin
            pick_idx = {1'b0, rr_ptr} + 4'(i);
            if (en_dbl[pick_idx]) begin
                pick_port = (pick_idx >= 4'd5) ? 3'(pick_idx - 4'd5) : pick_idx[2:0];
            end
        end
    end

    assign ready_vec = {m_axis_4_tready, m_axis_3_tready, m_axis_2_tready,
                        m_axis_1_tready, m_axis_0_tready};

    // tvalid is built only from registered state and FIFO occupancy, never from tready
    always_comb begin
        valid_vec = '0;
        for (int k = 0; k < 5; k++) begin
            valid_vec[k] = !axis_reset && (state == WR_PKT) && (sel_port == 3'(k)) && !empty;
        end
    end

    assign rd_en    = |(valid_vec & ready_vec);
    assign pkt_done = rd_en && head_last;

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state          <= IDLE;
            sel_port       <= '0;
            rr_ptr         <= '0;
            pkt_dispatched <= 1'b0;
        end else begin
            pkt_dispatched <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty && (port_en != '0)) begin
                        sel_port <= pick_port;
                        state    <= WR_PKT;
                    end
                end
                WR_PKT: begin
                    if (pkt_done) begin
                        state          <= IDLE;
                        rr_ptr         <= (sel_port == 3'd4) ? 3'd0 : sel_port + 3'd1;
                        pkt_dispatched <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
            pkt_cnt_2 <= '0;
            pkt_cnt_3 <= '0;
            pkt_cnt_4 <= '0;
        end else if (pkt_done) begin
            case (sel_port)
                3'd0:    pkt_cnt_0 <= pkt_cnt_0 + 32'd1;
                3'd1:    pkt_cnt_1 <= pkt_cnt_1 + 32'd1;
                3'd2:    pkt_cnt_2 <= pkt_cnt_2 + 32'd1;
                3'd3:    pkt_cnt_3 <= pkt_cnt_3 + 32'd1;
                3'd4:    pkt_cnt_4 <= pkt_cnt_4 + 32'd1;
                default: ;
            endcase
        end
    end

    // Head beat fans out to every port; only tvalid is per port
    assign m_axis_0_tdata  = head_data;
    assign m_axis_0_tkeep  = head_keep;
    assign m_axis_0_tuser  = head_user;
    assign m_axis_0_tlast  = head_last;
    assign m_axis_0_tvalid = valid_vec[0];

    assign m_axis_1_tdata  = head_data;
    assign m_axis_1_tkeep  = head_keep;
    assign m_axis_1_tuser  = head_user;
    assign m_axis_1_tlast  = head_last;
    assign m_axis_1_tvalid = valid_vec[1];

    assign m_axis_2_tdata  = head_data;
    assign m_axis_2_tkeep  = head_keep;
    assign m_axis_2_tuser  = head_user;
    assign m_axis_2_tlast  = head_last;
    assign m_axis_2_tvalid = valid_vec[2];

    assign m_axis_3_tdata  = head_data;
    assign m_axis_3_tkeep  = head_keep;
    assign m_axis_3_tuser  = head_user;
    assign m_axis_3_tlast  = head_last;
    assign m_axis_3_tvalid = valid_vec[3];

    assign m_axis_4_tdata  = head_data;
    assign m_axis_4_tkeep  = head_keep;
    assign m_axis_4_tuser  = head_user;
    assign m_axis_4_tlast  = head_last;
    assign m_axis_4_tvalid = valid_vec[4];

endmodule

// File: tb/tb_input_p4_dispatcher.sv
// tb/tb_input_p4_dispatcher.sv - randomized self-checking bench for input_p4_dispatcher
module tb_input_p4_dispatcher;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 304;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [DW-1:0]    s_tdata;
    logic [KW-1:0]    s_tkeep;
    logic [UW-1:0]    s_tuser;
    logic             s_tvalid;
    logic             s_tlast;
    wire              s_tready;
    logic [4:0]       m_rdy;
    logic [4:0]       port_en;
    wire  [4:0][DW-1:0] o_data;
    wire  [4:0][KW-1:0] o_keep;
    wire  [4:0][UW-1:0] o_user;
    wire  [4:0]       o_valid;
    wire  [4:0]       o_last;
    wire  [4:0][31:0] cnt;
    wire              pkt_disp;

    input_p4_dispatcher dut (
        .axis_aclk(clk), .axis_reset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_0_tdata(o_data[0]), .m_axis_0_tkeep(o_keep[0]), .m_axis_0_tuser(o_user[0]),
        .m_axis_0_tvalid(o_valid[0]), .m_axis_0_tready(m_rdy[0]), .m_axis_0_tlast(o_last[0]),
        .m_axis_1_tdata(o_data[1]), .m_axis_1_tkeep(o_keep[1]), .m_axis_1_tuser(o_user[1]),
        .m_axis_1_tvalid(o_valid[1]), .m_axis_1_tready(m_rdy[1]), .m_axis_1_tlast(o_last[1]),
        .m_axis_2_tdata(o_data[2]), .m_axis_2_tkeep(o_keep[2]), .m_axis_2_tuser(o_user[2]),
        .m_axis_2_tvalid(o_valid[2]), .m_axis_2_tready(m_rdy[2]), .m_axis_2_tlast(o_last[2]),
        .m_axis_3_tdata(o_data[3]), .m_axis_3_tkeep(o_keep[3]), .m_axis_3_tuser(o_user[3]),
        .m_axis_3_tvalid(o_valid[3]), .m_axis_3_tready(m_rdy[3]), .m_axis_3_tlast(o_last[3]),
        .m_axis_4_tdata(o_data[4]), .m_axis_4_tkeep(o_keep[4]), .m_axis_4_tuser(o_user[4]),
        .m_axis_4_tvalid(o_valid[4]), .m_axis_4_tready(m_rdy[4]), .m_axis_4_tlast(o_last[4]),
        .port_en(port_en),
        .pkt_cnt_0(cnt[0]), .pkt_cnt_1(cnt[1]), .pkt_cnt_2(cnt[2]),
        .pkt_cnt_3(cnt[3]), .pkt_cnt_4(cnt[4]),
        .pkt_dispatched(pkt_disp)
    );

    int          passed = 0;
    int          total  = 0;
    beat_t       src_q[$];
    beat_t       exp_q[$];
    int          port_log[$];
    logic [31:0] exp_cnt [5];
    int          model_ptr = 0;
    int          cur_port  = -1;
    int          pkt_beats = 0;
    int          npulse    = 0;
    int          cyc       = 0;
    int          lat_acc   = -1;
    int          lat_val   = -1;
    logic        pulse_due = 1'b0;
    logic        src_acc   = 1'b0;
    logic        src_gap   = 1'b0;
    logic        rdy_rand  = 1'b0;
    logic [4:0]  hold_low  = '0;
    logic [4:0]  prev_valid = '0;
    logic [4:0]  prev_hs    = '0;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference rule: first enabled port at or after the pointer, wrapping 4 -> 0
    function automatic int pick(input int ptr, input logic [4:0] en);
        for (int i = 0; i < 5; i++) begin
            if (en[(ptr + i) % 5]) return (ptr + i) % 5;
        end
        return -1;
    endfunction

    function automatic beat_t rnd_beat(input logic last);
        beat_t b;
        logic [319:0] t;
        for (int i = 0; i < 8; i++) b.d[i*32 +: 32] = $urandom;
        for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
        b.k = $urandom;
        b.u = t[UW-1:0];
        b.l = last;
        return b;
    endfunction

    task automatic push_pkt(input int len);
        for (int i = 0; i < len; i++) src_q.push_back(rnd_beat(i == len - 1));
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Source and sink-ready drivers, just after the active edge
    always @(posedge clk) begin
        #1;
        if (src_acc && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() > 0 && (!src_gap || $urandom_range(3) != 0)) begin
            s_tdata  = src_q[0].d;
            s_tkeep  = src_q[0].k;
            s_tuser  = src_q[0].u;
            s_tlast  = src_q[0].l;
            s_tvalid = 1'b1;
        end else begin
            s_tvalid = 1'b0;
        end
        for (int k = 0; k < 5; k++) begin
            m_rdy[k] = hold_low[k] ? 1'b0 : (rdy_rand ? ($urandom_range(3) != 0) : 1'b1);
        end
    end

    // Scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        int    p;
        beat_t b;
        if (rst) begin
            chk("rst_tvalid", o_valid, 5'b0);
            chk("rst_s_tready", s_tready, 1'b0);
            src_acc    = 1'b0;
            pulse_due  = 1'b0;
            prev_valid = '0;
            prev_hs    = '0;
        end else begin
            chk("s_tready_occ", s_tready, exp_q.size() < 63);
            chk("pkt_dispatched", pkt_disp, pulse_due);
            if (pkt_disp) npulse = npulse + 1;
            pulse_due = 1'b0;
            chk("onehot_tvalid", $countones(o_valid) <= 1, 1'b1);
            for (int k = 0; k < 5; k++) begin
                if (prev_valid[k] && !prev_hs[k]) chk($sformatf("hold_tvalid%0d", k), o_valid[k], 1'b1);
            end
            p = -1;
            for (int k = 0; k < 5; k++) if (o_valid[k]) p = k;
            if (p >= 0) begin
                if (cur_port < 0) begin
                    cur_port = pick(model_ptr, port_en);
                    port_log.push_back(cur_port);
                    if (lat_val < 0) lat_val = cyc;
                end
                chk("out_port", p, cur_port);
                if (m_rdy[p]) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1'b1, 1'b0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("tdata", o_data[p], b.d);
                        chk("tkeep", o_keep[p], b.k);
                        chk("tuser", o_user[p], b.u);
                        chk("tlast", o_last[p], b.l);
                        pkt_beats = pkt_beats + 1;
                        if (b.l) begin
                            exp_cnt[p] = exp_cnt[p] + 32'd1;
                            model_ptr  = (p + 1) % 5;
                            cur_port   = -1;
                            pkt_beats  = 0;
                            pulse_due  = 1'b1;
                        end
                    end
                end
            end
            src_acc = s_tvalid && s_tready;
            if (src_acc) begin
                b.d = s_tdata; b.k = s_tkeep; b.u = s_tuser; b.l = s_tlast;
                exp_q.push_back(b);
                if (lat_acc < 0) lat_acc = cyc;
            end
            prev_valid = o_valid;
            prev_hs    = o_valid & m_rdy;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_q.delete();
        exp_q.delete();
        s_tvalid  = 1'b0;
        cur_port  = -1;
        model_ptr = 0;
        pkt_beats = 0;
        for (int k = 0; k < 5; k++) exp_cnt[k] = '0;
        step();
        step();
        rst = 1'b0;
        step();
        npulse = 0;
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (src_q.size() == 0 && exp_q.size() == 0 && cur_port < 0 && !s_tvalid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("idle_timeout", ok, 1'b1);
        step();
        step();
    endtask

    task automatic check_cnts();
        for (int k = 0; k < 5; k++) chk($sformatf("pkt_cnt_%0d", k), cnt[k], exp_cnt[k]);
    endtask

    initial begin
        int rp;
        rst = 1'b1; port_en = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        s_tdata = '0; s_tkeep = '0; s_tuser = '0; m_rdy = '1;
        do_reset();
        chk("reset_disp", pkt_disp, 1'b0);
        check_cnts();

        // Five 3-beat packets round-robin over all ports, plus input-to-output latency
        port_en = 5'b11111;
        lat_acc = -1; lat_val = -1;
        port_log.delete();
        for (int i = 0; i < 5; i++) push_pkt(3);
        wait_idle(300);
        chk("latency", lat_val - lat_acc, 2);
        chk("rr_count", port_log.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), port_log[i], i);
        chk("pulses5", npulse, 5);
        check_cnts();

        // Sparse mask alternates between ports 2 and 4
        do_reset();
        port_en = 5'b10100;
        port_log.delete();
        for (int i = 0; i < 4; i++) push_pkt(1);
        wait_idle(200);
        chk("sparse_count", port_log.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("sparse%0d", i), port_log[i], (i % 2 == 0) ? 2 : 4);
        chk("cnt2_two", cnt[2], 32'd2);
        chk("cnt4_two", cnt[4], 32'd2);
        check_cnts();

        // Back-pressure: 70-beat packet against a stalled port 0
        port_en = 5'b00001;
        hold_low = 5'b00001;
        push_pkt(70);
        for (int i = 0; i < 80; i++) step();
        chk("fill_level", exp_q.size(), 63);
        chk("full_tready", s_tready, 1'b0);
        chk("full_tvalid0", o_valid[0], 1'b1);
        hold_low = '0;
        wait_idle(300);
        check_cnts();

        // No enabled port: packet waits, then goes to port 3 once enabled
        port_en = '0;
        push_pkt(2);
        for (int i = 0; i < 10; i++) step();
        chk("noen_tvalid", o_valid, 5'b0);
        chk("noen_queued", exp_q.size(), 2);
        port_en = 5'b01000;
        step();
        chk("en3_tvalid", o_valid, 5'b01000);
        wait_idle(100);
        check_cnts();

        // Dropping the enable of the active port mid-packet does not redirect it
        port_en = 5'b11111;
        rdy_rand = 1'b1;
        push_pkt(6);
        rp = -1;
        for (int i = 0; i < 50 && rp < 0; i++) begin
            step();
            rp = cur_port;
        end
        chk("midpkt_started", rp >= 0, 1'b1);
        if (rp >= 0) port_en = 5'b11111 & ~(5'b00001 << rp);
        wait_idle(200);
        check_cnts();
        rdy_rand = 1'b0;

        // Reset during beat 2 of a packet on port 1
        do_reset();
        port_en = 5'b11111;
        push_pkt(1);
        wait_idle(100);
        m_rdy = '1;
        rdy_rand = 1'b1;
        push_pkt(4);
        rp = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (cur_port == 1 && pkt_beats == 1) begin
                rp = 1;
                break;
            end
        end
        rdy_rand = 1'b0;
        chk("midpkt_reached", rp, 1);
        do_reset();
        chk("after_rst_tvalid", o_valid, 5'b0);
        chk("after_rst_cnt1", cnt[1], 32'd0);
        port_en = 5'b11111;
        port_log.delete();
        push_pkt(2);
        wait_idle(100);
        chk("after_rst_port", port_log.size() > 0 ? port_log[0] : -1, 0);
        check_cnts();

        // Counter wrap on port 3
        force dut.pkt_cnt_3 = 32'hFFFF_FFFF;
        step();
        release dut.pkt_cnt_3;
        exp_cnt[3] = 32'hFFFF_FFFF;
        step();
        chk("cnt3_preload", cnt[3], 32'hFFFF_FFFF);
        port_en = 5'b01000;
        push_pkt(2);
        wait_idle(100);
        chk("cnt3_wrap", cnt[3], 32'd0);
        check_cnts();

        // Randomized traffic with throttled source and sinks
        rdy_rand = 1'b1;
        src_gap  = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (n % 6 == 0) begin
                wait_idle(2000);
                port_en = 5'($urandom_range(1, 31));
            end
            push_pkt($urandom_range(1, 8));
        end
        wait_idle(4000);
        check_cnts();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
